// File: rtl/text_writer.sv
// text_writer: host-side character writer for an 80x25 text display.
// It takes bytes over a valid/ready handshake, writes printable characters
// into the screen and colour RAMs, and handles the CR, LF, BS and FF codes.
// RAM addresses are {row[4:0], col[6:0]}, which matches the scan-out logic.

module text_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 25,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  parameter logic [7:0]  RESET_ATTR = 8'hFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic [7:0]  attr,
  input  logic        valid,
  output logic        ready_o,
  output logic [11:0] wr_addr_o,
  output logic [7:0]  wr_char_o,
  output logic [7:0]  wr_colr_o,
  output logic        wren_ms_o,
  output logic        wren_mc_o,
  output logic [6:0]  cursor_x_o,
  output logic [4:0]  cursor_y_o
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] COLS_W   = 7'(COLS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] ROWS_W   = 5'(ROWS);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    WRITE,
    CLR_LINE,
    CLR_SCREEN
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [7:0]  attr_q, attr_d;
  logic        ready_q, ready_d;
  logic        wren_q, wren_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  colr_q, colr_d;

  logic        accept;
  logic        printable;
  logic [4:0]  next_row;

  assign accept    = valid && ready_q && (state_q == IDLE);
  assign printable = (data >= 8'h20) && (data <= 8'h7E);
  assign next_row  = (cur_y_q == LAST_ROW) ? 5'd0 : cur_y_q + 5'd1;

  // Next-state logic: the byte decode, the cursor movement and the clear sequencers.
  // Each clear state spends its entry cycle idle, then issues one write per cycle,
  // and leaves one cycle after its last write so that ready rises as wren falls.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    attr_d    = attr_q;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    char_d    = char_q;
    colr_d    = colr_q;

    case (state_q)
      INIT_CLR, CLR_SCREEN: begin
        if (clr_row_q == ROWS_W) begin
          state_d = IDLE;
          cur_x_d = 7'd0;
          cur_y_d = 5'd0;
        end else begin
          wren_d = 1'b1;
          addr_d = {clr_row_q, clr_col_q};
          char_d = BLANK_CHAR;
          colr_d = (state_q == INIT_CLR) ? RESET_ATTR : attr_q;
          if (clr_col_q == LAST_COL) begin
            clr_col_d = 7'd0;
            clr_row_d = clr_row_q + 5'd1;
          end else begin
            clr_col_d = clr_col_q + 7'd1;
          end
        end
      end

      CLR_LINE: begin
        if (clr_col_q == COLS_W) begin
          state_d = IDLE;
        end else begin
          wren_d    = 1'b1;
          addr_d    = {cur_y_q, clr_col_q};
          char_d    = BLANK_CHAR;
          colr_d    = attr_q;
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      WRITE: begin
        if (cur_x_q == LAST_COL) begin
          cur_x_d   = 7'd0;
          cur_y_d   = next_row;
          clr_col_d = 7'd0;
          state_d   = CLR_LINE;
        end else begin
          cur_x_d = cur_x_q + 7'd1;
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (accept) begin
          attr_d = attr;
          if (printable) begin
            state_d = WRITE;
            wren_d  = 1'b1;
            addr_d  = {cur_y_q, cur_x_q};
            char_d  = data;
            colr_d  = attr;
          end else begin
            case (data)
              CODE_CR: cur_x_d = 7'd0;
              CODE_LF: begin
                cur_x_d   = 7'd0;
                cur_y_d   = next_row;
                clr_col_d = 7'd0;
                state_d   = CLR_LINE;
              end
              CODE_BS: begin
                if (cur_x_q != 7'd0) begin
                  cur_x_d = cur_x_q - 7'd1;
                end
              end
              CODE_FF: begin
                clr_col_d = 7'd0;
                clr_row_d = 5'd0;
                state_d   = CLR_SCREEN;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) && !accept;
  end

  // State and registered outputs; reset aborts any write or clear immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_CLR;
      cur_x_q   <= 7'd0;
      cur_y_q   <= 5'd0;
      clr_col_q <= 7'd0;
      clr_row_q <= 5'd0;
      attr_q    <= 8'd0;
      ready_q   <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= 12'd0;
      char_q    <= 8'd0;
      colr_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      attr_q    <= attr_d;
      ready_q   <= ready_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      char_q    <= char_d;
      colr_q    <= colr_d;
    end
  end

  assign ready_o    = ready_q;
  assign wr_addr_o  = addr_q;
  assign wr_char_o  = char_q;
  assign wr_colr_o  = colr_q;
  assign wren_ms_o  = wren_q;
  assign wren_mc_o  = wren_q;
  assign cursor_x_o = cur_x_q;
  assign cursor_y_o = cur_y_q;

endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed scoreboard bench for text_writer.
// Stimulus pushes every expected RAM write into a queue; a negedge monitor
// pops and compares each write the design presents.

module tb_text_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data = 8'h00;
  logic [7:0]  attr = 8'h00;
  logic        valid = 1'b0;
  logic        ready_o;
  logic [11:0] wr_addr_o;
  logic [7:0]  wr_char_o;
  logic [7:0]  wr_colr_o;
  logic        wren_ms_o;
  logic        wren_mc_o;
  logic [6:0]  cursor_x_o;
  logic [4:0]  cursor_y_o;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  ch;
    logic [7:0]  colr;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  writes_seen = 0;

  text_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .attr       (attr),
    .valid      (valid),
    .ready_o    (ready_o),
    .wr_addr_o  (wr_addr_o),
    .wr_char_o  (wr_char_o),
    .wr_colr_o  (wr_colr_o),
    .wren_ms_o  (wren_ms_o),
    .wren_mc_o  (wren_mc_o),
    .cursor_x_o (cursor_x_o),
    .cursor_y_o (cursor_y_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushWrite(input int row, input int col, input logic [7:0] ch, input logic [7:0] colr);
    wr_t e;
    e.addr = {5'(row), 7'(col)};
    e.ch   = ch;
    e.colr = colr;
    sb.push_back(e);
  endtask

  task automatic pushLine(input int row, input logic [7:0] colr);
    for (int c = 0; c < 80; c++) pushWrite(row, c, 8'h20, colr);
  endtask

  task automatic pushScreen(input logic [7:0] colr);
    for (int r = 0; r < 25; r++) pushLine(r, colr);
  endtask

  // Counts negedges on which ready_o is still low; gives up after a bound.
  task automatic waitReady(input int bound, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n >= bound) begin
        total++;
        bad++;
        $display("[TB] FAIL ready timeout: got %0d cycles expected under %0d", n, bound);
        break;
      end
    end
  endtask

  // Offers one byte and holds it until the design accepts it.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] a);
    int k;
    data  = d;
    attr  = a;
    valid = 1'b1;
    k = 0;
    while (!ready_o && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: got ready %0b expected 1", ready_o);
    end
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic checkCursor(input string name, input int x, input int y);
    checkOutput({name, " x"}, 32'(cursor_x_o), 32'(x));
    checkOutput({name, " y"}, 32'(cursor_y_o), 32'(y));
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " wren"}, {wren_ms_o, wren_mc_o}, 0);
    checkOutput({name, " addr/char/colr"}, {wr_addr_o, wr_char_o, wr_colr_o}, 0);
    checkOutput({name, " ready"}, 32'(ready_o), 0);
    checkCursor(name, 0, 0);
  endtask

  // Scoreboard monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wren_ms_o || wren_mc_o)) begin
      writes_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected write: got addr %0h char %0h colr %0h expected no write",
                 wr_addr_o, wr_char_o, wr_colr_o);
      end else begin
        wr_t e;
        e = sb.pop_front();
        checkOutput("write {mc,addr,char,colr}",
                    {wren_mc_o, wr_addr_o, wr_char_o, wr_colr_o},
                    {1'b1, e.addr, e.ch, e.colr});
      end
    end
  end

  initial begin
    int n;
    int base;
    int k;
    logic [7:0] chars [7];

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");

    // Power-on clear
    pushScreen(8'hFC);
    rst_n = 1'b1;
    waitReady(3000, n);
    checkOutput("init busy", n, 2000);
    checkOutput("init writes left", sb.size(), 0);
    checkCursor("init cursor", 0, 0);

    // Single character
    pushWrite(0, 0, 8'h41, 8'hC0);
    applyStimulus(8'h41, 8'hC0);
    waitReady(100, n);
    checkOutput("char busy", n, 1);
    checkCursor("char cursor", 1, 0);

    // Move to (79,3) and wrap
    for (int r = 1; r <= 3; r++) begin
      pushLine(r, 8'h0C);
      applyStimulus(8'h0A, 8'h0C);
      waitReady(200, n);
      checkOutput("lf busy", n, 81);
    end
    checkCursor("lf cursor", 0, 3);
    for (int c = 0; c < 79; c++) begin
      pushWrite(3, c, 8'h2E, 8'h14);
      applyStimulus(8'h2E, 8'h14);
      waitReady(100, n);
    end
    checkCursor("col79 cursor", 79, 3);
    pushWrite(3, 79, 8'h5A, 8'h2A);
    pushLine(4, 8'h2A);
    applyStimulus(8'h5A, 8'h2A);
    waitReady(200, n);
    checkOutput("wrap busy", n, 82);
    checkCursor("wrap cursor", 0, 4);
    checkOutput("wrap writes left", sb.size(), 0);

    // Bottom-row LF wraps to row 0
    for (int r = 5; r <= 24; r++) begin
      pushLine(r, 8'h07);
      applyStimulus(8'h0A, 8'h07);
      waitReady(200, n);
    end
    for (int c = 0; c < 10; c++) begin
      pushWrite(24, c, 8'(8'h30 + c), 8'h3F);
      applyStimulus(8'(8'h30 + c), 8'h3F);
      waitReady(100, n);
    end
    checkCursor("row24 cursor", 10, 24);
    pushLine(0, 8'h11);
    applyStimulus(8'h0A, 8'h11);
    waitReady(200, n);
    checkOutput("bottom lf busy", n, 81);
    checkCursor("bottom lf cursor", 0, 0);

    // Control codes
    for (int r = 1; r <= 5; r++) begin
      pushLine(r, 8'h00);
      applyStimulus(8'h0A, 8'h00);
      waitReady(200, n);
    end
    applyStimulus(8'h08, 8'h00);
    waitReady(100, n);
    checkOutput("bs col0 busy", n, 1);
    checkCursor("bs col0 cursor", 0, 5);
    chars = '{8'h20, 8'h7E, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    for (int c = 0; c < 7; c++) begin
      pushWrite(5, c, chars[c], 8'h55);
      applyStimulus(chars[c], 8'h55);
      waitReady(100, n);
    end
    checkCursor("seven chars cursor", 7, 5);
    applyStimulus(8'h08, 8'h00);
    waitReady(100, n);
    checkCursor("bs cursor", 6, 5);
    applyStimulus(8'h0D, 8'h00);
    waitReady(100, n);
    checkOutput("cr busy", n, 1);
    checkCursor("cr cursor", 0, 5);
    applyStimulus(8'h01, 8'h00);
    waitReady(100, n);
    checkOutput("ignored 01 busy", n, 1);
    applyStimulus(8'h90, 8'h00);
    waitReady(100, n);
    applyStimulus(8'h7F, 8'h00);
    waitReady(100, n);
    applyStimulus(8'h1F, 8'h00);
    waitReady(100, n);
    checkCursor("ignored cursor", 0, 5);
    checkOutput("ctrl writes left", sb.size(), 0);

    // Full form feed
    pushScreen(8'h22);
    applyStimulus(8'h0C, 8'h22);
    waitReady(3000, n);
    checkOutput("ff busy", n, 2001);
    checkCursor("ff cursor", 0, 0);
    checkOutput("ff writes left", sb.size(), 0);

    // Reset in the middle of a form feed
    pushScreen(8'h30);
    base = writes_seen;
    applyStimulus(8'h0C, 8'h30);
    k = 0;
    while (writes_seen < base + 500 && k < 3000) begin
      @(negedge clk);
      #1 k++;
    end
    checkOutput("writes before abort", writes_seen - base, 500);
    #1 rst_n = 1'b0;
    #1 checkOutput("abort wren", {wren_ms_o, wren_mc_o}, 0);
    sb.delete();
    data  = 8'h51;
    attr  = 8'h03;
    valid = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState("abort reset");
    pushScreen(8'hFC);
    pushWrite(0, 0, 8'h51, 8'h03);
    rst_n = 1'b1;
    waitReady(3000, n);
    checkOutput("reinit busy", n, 2000);
    @(posedge clk);
    #1 valid = 1'b0;
    waitReady(100, n);
    checkOutput("held byte busy", n, 1);
    checkCursor("held byte cursor", 1, 0);
    repeat (3) @(negedge clk);
    checkOutput("final writes left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_writer.md
# text_writer

Host-side writer for the 80x25 text-mode display: accepts a byte stream plus colour attribute over a valid/ready handshake and writes characters into the screen RAM and colour RAM. It owns the cursor and interprets a small set of control codes: CR, LF, BS and FF. It drives the write ports of the same screen/colour RAMs that the scan-out logic reads. The RAM address format matches scan-out: bits [6:0] are the column and bits [11:7] are the row.

## Interface
- COLS, 80, characters per row (column 0..COLS-1)
- ROWS, 25, rows per screen (row 0..ROWS-1)
- BLANK_CHAR, 8'h20, character code written by all clear operations
- RESET_ATTR, 8'hFC, colour attribute written by the power-on clear
- clk  input  1  system clock (the same clock as the RAM ports)
- rst_n  input  1  reset, asynchronous, active-low
- data  input  8  character/control byte
- attr  input  8  colour attribute for this byte ([7:6] R, [5:4] G, [3:2] B)
- valid  input  1  data/attr valid
- ready_o  output  1  block can accept a byte this cycle
- wr_addr_o  output  12  RAM address {row[4:0], col[6:0]}
- wr_char_o  output  8  screen RAM write data
- wr_colr_o  output  8  colour RAM write data
- wren_ms_o  output  1  screen RAM write enable
- wren_mc_o  output  1  colour RAM write enable, always equal to wren_ms_o
- cursor_x_o  output  7  column of the next character write
- cursor_y_o  output  5  row of the next character write

## Operation
- **States:** INIT_CLR, IDLE, WRITE, CLR_LINE, CLR_SCREEN. `ready_o` is high only in IDLE.
- **Byte acceptance:** a byte is accepted on a rising edge with `valid & ready_o`. `data` and `attr` are latched on that edge.
- **Printable bytes (0x20-0x7E):** IDLE -> WRITE. In WRITE, one write of `{char, attr}` goes to the cursor address, then the cursor advances.
  - If col < COLS-1: col+1, return to IDLE.
  - If col == COLS-1: col=0, row = (row==ROWS-1) ? 0 : row+1, then go to CLR_LINE for the new row.
- **CR 0x0D:** col=0, no write, IDLE -> IDLE. The block is not ready for 1 cycle.
- **LF 0x0A:** col=0, row advances with wrap as above, then CLR_LINE of the new row.
- **BS 0x08:** col = col-1 if col>0, else no change. No write; the cursor does not move up a row.
- **FF 0x0C:** go to CLR_SCREEN, then cursor = (0,0).
- **Other bytes:** any other value <0x20, or 0x7F-0xFF, is consumed with no write and no cursor change.
- **CLR_LINE:** COLS consecutive writes of `{BLANK_CHAR, latched attr}` to cols 0..COLS-1 of the new row, then IDLE. The cursor is already at (0, new row) during the clear.
- **CLR_SCREEN / INIT_CLR:** ROWS*COLS consecutive writes, row-major from (0,0) to (ROWS-1, COLS-1).
  - Colour is the latched attr in CLR_SCREEN and RESET_ATTR in INIT_CLR.
  - Both then go to IDLE with cursor (0,0).
- **Addressing:** addresses are never linear. Col 80..127 and row 25..31 are never driven.
- **Reset:** asynchronous. All outputs clear immediately: wren low, addr/char/colr 0, cursor (0,0), ready_o 0. The state becomes INIT_CLR with its counter at (0,0).
  - Reset mid-clear or mid-write aborts with no further writes.

## Timing
- All outputs are registered.
- **Printable byte accepted on edge N:**
  - ready_o falls after N.
  - wren/addr/data are valid for the cycle after N, sampled by the RAM on edge N+1.
  - The cursor updates on N+1.
  - ready_o is high again after N+1 (no wrap), so throughput is one printable byte per 2 cycles.
- **Control bytes:** CR/BS/ignored bytes take 1 busy cycle; ready_o is high again after N+1.
- **Line clear:** LF or wrap -> ready_o low for 1+COLS cycles (81 by default). Writes occupy the COLS cycles after the state entry edge.
- **Screen clear:** FF -> ready_o low for 1+ROWS*COLS cycles (2001).
- **Power-on clear:** after rst_n deasserts, 2000 write cycles start on the first rising edge. ready_o first goes high on edge 2001.
- **Write enables:** wren_ms_o and wren_mc_o are identical every cycle. Outside WRITE/CLR_* states they are 0.
- **valid while not ready:** valid asserted while ready_o is low is ignored. The source holds data/attr until acceptance.

## Test plan
- **Reset clear:** release rst_n -> exactly 2000 writes, addresses {r,c} for r 0..24 and c 0..79 in order, char 0x20, colr 0xFC -> ready_o=1 on edge 2001, cursor (0,0).
- **Single character:** send 'A' (0x41) with attr 0xC0 at cursor (0,0) -> one write addr 0x000, char 0x41, colr 0xC0 -> cursor (1,0), ready after 2 cycles.
- **Wrap at column 79:** with cursor at (79,3), send 'Z' -> write at addr {3,79}=0x1CF -> 80 writes of 0x20 to row 4 (0x200..0x24F) -> cursor (0,4).
- **Bottom wrap on LF:** at row 24, col 10, send LF -> no char write; row 0 cleared (0x000..0x04F) -> cursor (0,0).
- **Control codes:**
  - BS at (0,5) -> cursor stays (0,5).
  - BS at (7,5) -> cursor (6,5).
  - CR -> (0,5).
  - 0x01 and 0x90 -> no writes, cursor unchanged.
- **Reset during FF clear:** send FF with attr 0x30, assert rst_n low at write 500 -> wren drops asynchronously. After release, a full INIT_CLR with colr 0xFC runs; back-pressure holds valid data until ready_o.
